// File: rtl/iq_sample_fifo_pkg.sv
// iq_sample_fifo_pkg: shared baseband defaults for the IQ sample FIFO.
//   ADC_IQ_WIDTH_DEF - default signed width of each I and Q sample
//   DROP_CNT_WIDTH   - width of the saturating drop counter
//   iq_pack_width()  - width of one packed {I,Q} word
package iq_sample_fifo_pkg;
    localparam int ADC_IQ_WIDTH_DEF = 12;
    localparam int DROP_CNT_WIDTH = 16;
    function automatic int iq_pack_width(input int w);
        return 2 * w;
    endfunction
endpackage

// File: rtl/iq_fifo_mem.sv
// iq_fifo_mem: simple dual-port array, synchronous write, asynchronous read.
//   clk     - write clock
//   we      - write enable
//   wr_addr - write address, wr_data - word written
//   rd_addr - read address, rd_data - word at rd_addr (combinational)
module iq_fifo_mem #(
    parameter int WIDTH = 24,
    parameter int AW = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/iq_sample_fifo.sv
// iq_sample_fifo: IQ sample FIFO with valid/ready output, fill level and drop tracking.
//   clk_adc, rstn          - baseband clock, async active-low reset
//   en, flush              - write enable, synchronous clear
//   iq_valued, i_data, q_data - sample strobe and signed I/Q sample
//   m_valid, m_data, m_ready  - output stream, m_data = {I,Q}
//   level, half_full       - stored entries, level >= half depth
//   overflow, drop_cnt, ovf_clr - sticky drop flag, saturating drop count, clear
module iq_sample_fifo
    import iq_sample_fifo_pkg::*;
#(
    parameter int ADC_IQ_WIDTH = ADC_IQ_WIDTH_DEF,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                                    clk_adc,
    input  logic                                    rstn,
    input  logic                                    en,
    input  logic                                    flush,
    input  logic                                    iq_valued,
    input  logic [ADC_IQ_WIDTH-1:0]                 i_data,
    input  logic [ADC_IQ_WIDTH-1:0]                 q_data,
    output logic                                    m_valid,
    output logic [iq_pack_width(ADC_IQ_WIDTH)-1:0]  m_data,
    input  logic                                    m_ready,
    output logic [DEPTH_LOG2:0]                     level,
    output logic                                    half_full,
    output logic                                    overflow,
    input  logic                                    ovf_clr,
    output logic [DROP_CNT_WIDTH-1:0]               drop_cnt
);
    localparam int PW = iq_pack_width(ADC_IQ_WIDTH);
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [PW-1:0] rd_data;
    logic push_req, pop, full, push, drop;

    // level never exceeds the depth, so its top bit alone marks full,
    // and the top two bits together cover level >= depth/2
    assign level     = wr_ptr - rd_ptr;
    assign full      = level[DEPTH_LOG2];
    assign half_full = level[DEPTH_LOG2] | level[DEPTH_LOG2-1];
    assign m_valid   = |level;
    assign m_data    = m_valid ? rd_data : '0;

    always_comb begin
        push_req = en && iq_valued && !flush;
        pop      = m_valid && m_ready && !flush;
        // a pop in the same cycle frees the slot the push lands in
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    iq_fifo_mem #(.WIDTH(PW), .AW(DEPTH_LOG2)) u_mem (
        .clk     (clk_adc),
        .we      (push),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data ({i_data, q_data}),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_adc or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // a drop coinciding with ovf_clr restarts the count at one
    always_ff @(posedge clk_adc or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= ovf_clr ? CNT_ONE : (&drop_cnt ? drop_cnt : drop_cnt + CNT_ONE);
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule
